lfsr_seg_gen: RTL and testbench
===============================

// Module: lfsr_seg_gen
// PURPOSE
//  Parametrised Fibonacci LFSR random-number generator with 7-segment decode of every nibble.
//  Sits between NVBoard clk/buttons/switches and the seg displays.
//  Extends the fixed 8-bit free-running LFSR with:
//   - configurable width and taps
//   - prescaled free-run or button single-step mode
//   - runtime seed load
//   - all-zero lock-up recovery
//   - full-period wrap indication
// PARAMETERS
//  WIDTH     16      LFSR width; multiple of 4, range 8..32; NDIG = WIDTH/4 display digits
//  TAPS      16'h002D  feedback mask (bit i set = random_num[i] in XOR); default x^16+x^14+x^13+x^11+1
//  SEED      1       reset/recovery state; must be non-zero
//  PRESCALE  0       free-run mode advances once every PRESCALE+1 enabled cycles; 0..2^16-1
// PORTS
//  clk         in   1         clock
//  rst         in   1         reset, asynchronous, active-high
//  en          in   1         1 = run; 0 = freeze LFSR, prescaler and wrap (synchroniser keeps sampling)
//  mode        in   1         0 = free-run (prescaled), 1 = single-step on step rising edge
//  step        in   1         asynchronous button level, used in mode 1 only
//  load        in   1         synchronous seed load strobe
//  seed_in     in   WIDTH     value loaded on load
//  random_num  out  WIDTH     current LFSR state (registered)
//  hex         out  8*NDIG    hex[8k+7:8k] = active-low seg code of random_num[4k+3:4k]
//  lockup      out  1         1-cycle registered pulse: zero state/seed detected and replaced by SEED
//  wrap        out  1         1-cycle registered pulse: an advance produced state == SEED
// BEHAVIOUR
//  Reset values
//   - random_num = SEED
//   - prescaler count = 0
//   - step sync/edge flops = 0
//   - lockup = 0, wrap = 0
//   - hex = decode(SEED)
//  Advance
//   - fb = ^(random_num & TAPS)
//   - random_num <= {fb, random_num[WIDTH-1:1]}
//  Advance condition (en=1, load=0)
//   - mode 0: prescaler count == PRESCALE; count then returns to 0, else increments
//   - mode 1: step_edge = s2 & ~s3, where s1->s2->s3 is a 3-flop chain on step
//   - mode 1: exactly one advance per rising edge however long step is held
//   - mode 1: prescaler held at 0
//   - step rising edge before clk edge n -> random_num changes at edge n+2
//  Priority: rst > load > lock-up recovery > advance > hold
//  load (any en)
//   - random_num <= seed_in, prescaler <= 0
//   - seed_in == 0 -> random_num <= SEED and lockup pulses next cycle
//  Lock-up recovery
//   - random_num == 0 at an advance point -> load SEED instead of shifting
//   - lockup pulses next cycle
//  wrap
//   - pulses the cycle after any advance whose new value == SEED
//   - not raised by load, reset or recovery
//   - default taps: period 2^WIDTH-1, so wrap fires every 65535 advances
//  Mode change mid-count
//   - prescaler cleared on the mode change edge
//   - no spurious advance: edge detector ignores step history while mode == 0
//  hex
//   - combinational from random_num; zero latency
//   - table 0..F: 03 9F 25 0D 99 49 41 1F 01 09 11 C1 63 85 61 71
//   - default branch FD, unreachable
//  Async rst mid-count or mid-step
//   - immediate return to reset values
//   - a step held high across reset release gives no advance until released and pressed again
// TESTING
//  1. WIDTH=8, TAPS=8'h1D, SEED=1, mode0, PRESCALE=0:
//     - reset -> random_num 01, hex[7:0]=9F, hex[15:8]=03
//     - next states: 80, 40, 20, 10, 88
//  2. Same config, free-run 255 cycles -> wrap pulses exactly once, on the cycle after the state returns to 01
//  3. load with seed_in=A5 -> random_num A5, hex[7:0]=49, hex[15:8]=11
//     - then load 00 -> random_num 01, one-cycle lockup pulse
//  4. PRESCALE=3 -> advances every 4th cycle (01 -> 80 after 4 enabled cycles)
//     - en=0 for 10 cycles -> state and count frozen
//  5. mode1: step held high 20 cycles -> exactly one advance, 2 edges after capture
//     - three presses -> 01 -> 80 -> 40 -> 20
//     - held step while switching mode 0 -> 1 -> no advance
//  6. rst asserted mid-run at state 88 and mid-prescale
//     - immediate 01, count 0, lockup/wrap 0, hex back to 9F/03

Source files
------------

// File: rtl/lfsr_seg_gen_if.sv
// Handshake bundle between the board I/O (switches, button, seed) and the LFSR generator.
// The generator sits on the slave side; the board or bench drives the master side.
interface lfsr_seg_gen_if #(
    parameter int WIDTH = 16
);
    localparam int NDIG = WIDTH / 4;

    logic                  en;
    logic                  mode;
    logic                  step;
    logic                  load;
    logic [WIDTH-1:0]      seed_in;
    logic [WIDTH-1:0]      random_num;
    logic [8*NDIG-1:0]     hex;
    logic                  lockup;
    logic                  wrap;

    modport master (
        output en, mode, step, load, seed_in,
        input  random_num, hex, lockup, wrap
    );

    modport slave (
        input  en, mode, step, load, seed_in,
        output random_num, hex, lockup, wrap
    );
endinterface

// File: rtl/lfsr_seg_gen.sv
// Fibonacci LFSR with prescaled free-run or button single-step advance, seed load,
// zero-state recovery, period-wrap pulse and active-low 7-segment decode of every nibble.
module lfsr_seg_gen #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] TAPS     = WIDTH'(16'h002D),
    parameter int               SEED     = 1,
    parameter int               PRESCALE = 0
) (
    input  logic             clk,
    input  logic             rst,
    lfsr_seg_gen_if.slave    bus
);
    localparam int               NDIG   = WIDTH / 4;
    localparam logic [15:0]      PS     = 16'(PRESCALE);
    localparam logic [WIDTH-1:0] SEED_V = WIDTH'(SEED);

    function automatic logic [7:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'h0: seg_decode = 8'h03;
            4'h1: seg_decode = 8'h9F;
            4'h2: seg_decode = 8'h25;
            4'h3: seg_decode = 8'h0D;
            4'h4: seg_decode = 8'h99;
            4'h5: seg_decode = 8'h49;
            4'h6: seg_decode = 8'h41;
            4'h7: seg_decode = 8'h1F;
            4'h8: seg_decode = 8'h01;
            4'h9: seg_decode = 8'h09;
            4'hA: seg_decode = 8'h11;
            4'hB: seg_decode = 8'hC1;
            4'hC: seg_decode = 8'h63;
            4'hD: seg_decode = 8'h85;
            4'hE: seg_decode = 8'h61;
            4'hF: seg_decode = 8'h71;
            default: seg_decode = 8'hFD;
        endcase
    endfunction

    logic [WIDTH-1:0] r_state;
    logic [15:0]      r_cnt;
    logic             r_s1, r_s2, r_s3;
    logic             r_started, r_armed;
    logic             r_mode_q;
    logic             r_lockup, r_wrap;

    logic             w_mode_chg;
    logic [15:0]      w_cnt_eff;
    logic             w_step_edge;
    logic             w_tick;
    logic             w_fb;
    logic [WIDTH-1:0] w_next;

    // A mode change restarts the prescaler in the same cycle it is seen.
    assign w_mode_chg  = bus.mode ^ r_mode_q;
    assign w_cnt_eff   = w_mode_chg ? 16'd0 : r_cnt;
    // r_armed blocks a press that was already held when reset released.
    assign w_step_edge = bus.mode & r_armed & r_s2 & ~r_s3;
    assign w_tick      = bus.mode ? w_step_edge : (w_cnt_eff == PS);
    assign w_fb        = ^(r_state & TAPS);
    assign w_next      = {w_fb, r_state[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= SEED_V;
            r_cnt     <= '0;
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_s3      <= 1'b0;
            r_started <= 1'b0;
            r_armed   <= 1'b0;
            r_mode_q  <= 1'b0;
            r_lockup  <= 1'b0;
            r_wrap    <= 1'b0;
        end else begin
            r_s1      <= bus.step;
            r_s2      <= r_s1;
            // In free-run mode s3 tracks s1 so a held button leaves no pending edge.
            r_s3      <= bus.mode ? r_s2 : r_s1;
            r_started <= 1'b1;
            if (r_started && !r_s1)
                r_armed <= 1'b1;
            r_mode_q  <= bus.mode;
            r_lockup  <= 1'b0;
            r_wrap    <= 1'b0;

            if (bus.load) begin
                r_cnt <= '0;
                if (bus.seed_in == '0) begin
                    r_state  <= SEED_V;
                    r_lockup <= 1'b1;
                end else begin
                    r_state  <= bus.seed_in;
                end
            end else if (bus.en) begin
                if (bus.mode || (w_cnt_eff == PS))
                    r_cnt <= '0;
                else
                    r_cnt <= 16'(w_cnt_eff + 16'd1);

                if (w_tick) begin
                    if (r_state == '0) begin
                        r_state  <= SEED_V;
                        r_lockup <= 1'b1;
                    end else begin
                        r_state  <= w_next;
                        r_wrap   <= (w_next == SEED_V);
                    end
                end
            end else if (w_mode_chg) begin
                r_cnt <= '0;
            end
        end
    end

    assign bus.random_num = r_state;
    assign bus.lockup     = r_lockup;
    assign bus.wrap       = r_wrap;

    always_comb begin
        bus.hex = '0;
        for (int k = 0; k < NDIG; k++)
            bus.hex[8*k +: 8] = seg_decode(r_state[4*k +: 4]);
    end
endmodule

// File: tb/tb_lfsr_seg_gen.sv
// Directed bench for lfsr_seg_gen: 8-bit LFSR, taps 1D, seed 01, one free-run
// instance with no prescale (u0) and one with PRESCALE=3 (u3).
module tb_lfsr_seg_gen;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;
    int   wraps;

    lfsr_seg_gen_if #(.WIDTH(8)) if0 ();
    lfsr_seg_gen_if #(.WIDTH(8)) if3 ();

    lfsr_seg_gen #(.WIDTH(8), .TAPS(8'h1D), .SEED(1), .PRESCALE(0)) u0 (
        .clk(clk), .rst(rst), .bus(if0)
    );
    lfsr_seg_gen #(.WIDTH(8), .TAPS(8'h1D), .SEED(1), .PRESCALE(3)) u3 (
        .clk(clk), .rst(rst), .bus(if3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] seq [5];
        seq[0] = 8'h80; seq[1] = 8'h40; seq[2] = 8'h20; seq[3] = 8'h10; seq[4] = 8'h88;
        n_checks = 0;
        n_err    = 0;
        rst = 1'b1;
        if0.en = 1'b1; if0.mode = 1'b0; if0.step = 1'b0; if0.load = 1'b0; if0.seed_in = 8'h00;
        if3.en = 1'b1; if3.mode = 1'b0; if3.step = 1'b0; if3.load = 1'b0; if3.seed_in = 8'h00;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_state", 32'(if0.random_num), 32'h01);
        chk("rst_hex", 32'(if0.hex), 32'h039F);
        chk("rst_lockup", 32'(if0.lockup), 32'h0);
        chk("rst_wrap", 32'(if0.wrap), 32'h0);
        chk("rst_state_p3", 32'(if3.random_num), 32'h01);
        rst = 1'b0;

        // first advances, and prescale=3 timing on u3
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("seq%0d", i), 32'(if0.random_num), 32'(seq[i]));
            if (i == 2) chk("p3_hold", 32'(if3.random_num), 32'h01);
            if (i == 3) chk("p3_adv", 32'(if3.random_num), 32'h80);
        end
        chk("hex_88", 32'(if0.hex), 32'h0101);

        // full period: 255th advance returns to 01 with a wrap pulse
        wraps = 0;
        for (int i = 1; i <= 250; i++) begin
            @(negedge clk);
            if (if0.wrap) wraps++;
            if (i == 250) begin
                chk("period_state", 32'(if0.random_num), 32'h01);
                chk("period_wrap", 32'(if0.wrap), 32'h1);
            end
        end
        chk("wrap_count", 32'(wraps), 32'd1);
        @(negedge clk);
        chk("wrap_clear", 32'(if0.wrap), 32'h0);
        chk("after_wrap", 32'(if0.random_num), 32'h80);

        // seed load, then zero seed replaced by SEED with lockup pulse
        if0.load = 1'b1; if0.seed_in = 8'hA5;
        @(negedge clk);
        chk("load_a5", 32'(if0.random_num), 32'hA5);
        chk("load_hex", 32'(if0.hex), 32'h1149);
        chk("load_nolock", 32'(if0.lockup), 32'h0);
        if0.seed_in = 8'h00;
        @(negedge clk);
        chk("load0_state", 32'(if0.random_num), 32'h01);
        chk("load0_lockup", 32'(if0.lockup), 32'h1);
        chk("load0_nowrap", 32'(if0.wrap), 32'h0);
        if0.load = 1'b0;
        @(negedge clk);
        chk("lockup_pulse", 32'(if0.lockup), 32'h0);
        chk("post_load", 32'(if0.random_num), 32'h80);

        // async reset at state 88 while u3 is mid-prescale
        repeat (4) @(negedge clk);
        chk("pre_rst_88", 32'(if0.random_num), 32'h88);
        rst = 1'b1;
        #1;
        chk("arst_state", 32'(if0.random_num), 32'h01);
        chk("arst_hex", 32'(if0.hex), 32'h039F);
        chk("arst_lockup", 32'(if0.lockup), 32'h0);
        chk("arst_wrap", 32'(if0.wrap), 32'h0);
        chk("arst_p3", 32'(if3.random_num), 32'h01);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // prescale restarts from 0, then freezes while en=0
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 3) chk("p3_cnt0_hold", 32'(if3.random_num), 32'h01);
            if (i == 4) chk("p3_cnt0_adv", 32'(if3.random_num), 32'h80);
        end
        repeat (2) @(negedge clk);
        if3.en = 1'b0;
        repeat (10) @(negedge clk);
        chk("en0_frozen", 32'(if3.random_num), 32'h80);
        if3.en = 1'b1;
        @(negedge clk);
        chk("en1_cnt3", 32'(if3.random_num), 32'h80);
        @(negedge clk);
        chk("en1_adv", 32'(if3.random_num), 32'h40);

        // single-step: button held across reset gives nothing
        rst = 1'b1; if0.mode = 1'b1; if0.step = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("held_rst", 32'(if0.random_num), 32'h01);
        if0.step = 1'b0;
        repeat (4) @(negedge clk);
        chk("held_release", 32'(if0.random_num), 32'h01);

        // one long press: exactly one advance, two edges after capture
        if0.step = 1'b1;
        @(negedge clk);
        chk("step_lat1", 32'(if0.random_num), 32'h01);
        @(negedge clk);
        chk("step_lat2", 32'(if0.random_num), 32'h01);
        @(negedge clk);
        chk("step_adv", 32'(if0.random_num), 32'h80);
        repeat (17) @(negedge clk);
        chk("step_held", 32'(if0.random_num), 32'h80);
        if0.step = 1'b0;
        repeat (4) @(negedge clk);

        if0.step = 1'b1;
        repeat (2) @(negedge clk);
        if0.step = 1'b0;
        repeat (4) @(negedge clk);
        chk("press2", 32'(if0.random_num), 32'h40);
        if0.step = 1'b1;
        repeat (2) @(negedge clk);
        if0.step = 1'b0;
        repeat (4) @(negedge clk);
        chk("press3", 32'(if0.random_num), 32'h20);

        // held button across a mode 0 -> 1 switch gives no advance
        if0.mode = 1'b0; if0.step = 1'b1;
        @(negedge clk);
        chk("mode0_run1", 32'(if0.random_num), 32'h10);
        @(negedge clk);
        chk("mode0_run2", 32'(if0.random_num), 32'h88);
        if0.mode = 1'b1;
        repeat (6) @(negedge clk);
        chk("mode_sw_held", 32'(if0.random_num), 32'h88);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
